// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an asynchronous PWM line and publishes coherent
// {period, high_time} pairs in clk cycles, with a sticky dead-line timeout.
module pwm_capture #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] TIMEOUT = 32'd2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       prime_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_tmp_q, hi_tmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic             rise_s, fall_s, at_limit_s;

  assign rise_s     = s2_q & ~s3_q;
  assign fall_s     = ~s2_q & s3_q;
  assign at_limit_s = (cnt_q == LIMIT_C);

  // Three-flop synchroniser; prime_q marks when s2 holds a real sample, so a
  // line that is high through reset release is not mistaken for being low.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // Measurement state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= ZERO_C;
      hi_tmp_q  <= ZERO_C;
      period_q  <= ZERO_C;
      high_q    <= ZERO_C;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_tmp_q  <= hi_tmp_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  // Next-state logic; in HIGH the limit outranks a fall, because a period
  // whose high phase alone reaches the limit can never be accepted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_tmp_d  = hi_tmp_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    locked_d  = locked_q;
    case (state_q)
      WAIT_LOW: begin
        cnt_d = ZERO_C;
        if (prime_q[1] && !s2_q) begin
          state_d = WAIT_RISE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_RISE: begin
        if (rise_s) begin
          cnt_d   = ONE_C;
          state_d = HIGH;
        end else begin
          cnt_d   = ZERO_C;
          state_d = WAIT_RISE;
        end
      end
      HIGH: begin
        if (at_limit_s) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = ZERO_C;
          state_d   = WAIT_LOW;
        end else if (fall_s) begin
          hi_tmp_d = cnt_q;
          cnt_d    = cnt_q + ONE_C;
          state_d  = LOW;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LOW: begin
        if (rise_s) begin
          period_d  = cnt_q;
          high_d    = hi_tmp_q;
          valid_d   = 1'b1;
          locked_d  = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = ONE_C;
          state_d   = HIGH;
        end else if (at_limit_s) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = ZERO_C;
          state_d   = WAIT_LOW;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        cnt_d   = ZERO_C;
        state_d = WAIT_LOW;
      end
    endcase
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: two instances (TIMEOUT 1000 and 100)
// share one PWM line and are compared every cycle against an edge-time model.
module tb_pwm_capture;

  typedef struct packed {
    logic [31:0] per;
    logic [31:0] hi;
    logic        vld;
    logic        to;
    logic        lk;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm = 1'b0;
  logic [31:0] per_a, hi_a, per_b, hi_b;
  logic        vld_a, to_a, lk_a, vld_b, to_b, lk_b;
  logic [66:0] obs_a, obs_b;

  int    total = 0;
  int    bad = 0;
  int    to_val [2] = '{1000, 100};
  int    mode [2];
  int    t_rise [2];
  int    t_fall [2];
  snap_t cur [2];
  snap_t pipe_a [$];
  snap_t pipe_b [$];
  snap_t exp_a, exp_b;
  int    n_s;
  logic  prev_v;
  logic  wq [$];

  pwm_capture #(.WIDTH(32), .TIMEOUT(32'd1000)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm), .period(per_a), .high_time(hi_a),
    .valid(vld_a), .timeout(to_a), .locked(lk_a)
  );

  pwm_capture #(.WIDTH(32), .TIMEOUT(32'd100)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm), .period(per_b), .high_time(hi_b),
    .valid(vld_b), .timeout(to_b), .locked(lk_b)
  );

  assign obs_a = {per_a, hi_a, vld_a, to_a, lk_a};
  assign obs_b = {per_b, hi_b, vld_b, to_b, lk_b};

  always #5 clk = ~clk;

  // Model: mode 0 = must see the line low, 1 = waiting to arm, 2 = measuring.
  // Times are sample numbers; outputs appear two edges after the sample.
  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      mode[k]   = 0;
      t_rise[k] = 0;
      t_fall[k] = 0;
      cur[k]    = '0;
    end
    pipe_a.delete();
    pipe_b.delete();
    repeat (2) begin
      pipe_a.push_back('0);
      pipe_b.push_back('0);
    end
    n_s    = 0;
    prev_v = 1'b0;
  endtask

  task automatic model_update(input int k, input logic v, input logic p);
    cur[k].vld = 1'b0;
    if (mode[k] == 0) begin
      if (!v) mode[k] = 1;
    end else if (mode[k] == 1) begin
      if (v && !p) begin
        mode[k]   = 2;
        t_rise[k] = n_s;
      end
    end else begin
      if (v && !p) begin
        cur[k].per = 32'(n_s - t_rise[k]);
        cur[k].hi  = 32'(t_fall[k] - t_rise[k]);
        cur[k].vld = 1'b1;
        cur[k].to  = 1'b0;
        cur[k].lk  = 1'b1;
        t_rise[k]  = n_s;
      end else if (n_s - t_rise[k] == to_val[k]) begin
        cur[k].to = 1'b1;
        cur[k].lk = 1'b0;
        mode[k]   = 0;
      end else if (!v && p) begin
        t_fall[k] = n_s;
      end
    end
  endtask

  task automatic tick(input logic v);
    pwm = v;
    @(posedge clk);
    #1;
    n_s++;
    model_update(0, v, prev_v);
    model_update(1, v, prev_v);
    pipe_a.push_back(cur[0]);
    pipe_b.push_back(cur[1]);
    exp_a  = pipe_a.pop_front();
    exp_b  = pipe_b.pop_front();
    prev_v = v;
  endtask

  task automatic add_level(input logic v, input int n);
    repeat (n) wq.push_back(v);
  endtask

  task automatic add_pulses(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) wq.push_back(1'b1);
      repeat (lo) wq.push_back(1'b0);
    end
  endtask

  task automatic do_reset(input int ncyc, input logic v);
    reset = 1'b1;
    pwm   = v;
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    do_reset(3, 1'b0);
    total += 2;
    if (obs_a !== 67'd0) begin bad++; $display("FAIL reset_a got=%h want=0", obs_a); end
    if (obs_b !== 67'd0) begin bad++; $display("FAIL reset_b got=%h want=0", obs_b); end
    wq.delete();
    add_level(1'b0, 4);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL idle_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL idle_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
  endtask

  task automatic test_steady();
    int nv_a = 0;
    int nv_b = 0;
    wq.delete();
    add_level(1'b0, 1);
    add_pulses(20, 80, 4);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      nv_a += int'(vld_a);
      nv_b += int'(vld_b);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL steady_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL steady_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    total += 4;
    if (nv_a !== 3) begin bad++; $display("FAIL steady_count_a got=%0d want=3", nv_a); end
    if (nv_b !== 3) begin bad++; $display("FAIL steady_count_b got=%0d want=3", nv_b); end
    if (per_a !== 32'd100 || hi_a !== 32'd20) begin bad++; $display("FAIL steady_pair got=%0d/%0d want=100/20", per_a, hi_a); end
    if (lk_a !== 1'b1 || to_a !== 1'b0) begin bad++; $display("FAIL steady_flags got=lk%b to%b want=lk1 to0", lk_a, to_a); end
  endtask

  task automatic test_duty_change();
    wq.delete();
    add_pulses(20, 80, 2);
    add_pulses(35, 65, 3);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL duty_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL duty_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
      if (vld_a) begin
        total++;
        if (!(per_a == 32'd100 && (hi_a == 32'd20 || hi_a == 32'd35))) begin
          bad++; $display("FAIL duty_mixed got=%0d/%0d want=100/20 or 100/35", per_a, hi_a);
        end
      end
    end
    total++;
    if (per_a !== 32'd100 || hi_a !== 32'd35) begin bad++; $display("FAIL duty_final got=%0d/%0d want=100/35", per_a, hi_a); end
  endtask

  task automatic test_timeout_low();
    int last_v = -1;
    int to_at = -1;
    bit seen = 1'b0;
    wq.delete();
    add_pulses(30, 70, 2);
    add_level(1'b0, 150);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      if (vld_b) last_v = n_s;
      if (to_b && to_at < 0) to_at = n_s;
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL tlow_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL tlow_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    total += 3;
    if (to_at - last_v !== 100) begin bad++; $display("FAIL tlow_delay got=%0d want=100", to_at - last_v); end
    if (per_b !== 32'd100 || hi_b !== 32'd30) begin bad++; $display("FAIL tlow_hold got=%0d/%0d want=100/30", per_b, hi_b); end
    if (to_b !== 1'b1 || lk_b !== 1'b0) begin bad++; $display("FAIL tlow_flags got=to%b lk%b want=to1 lk0", to_b, lk_b); end
    wq.delete();
    add_pulses(30, 70, 3);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL resume_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL resume_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
      if (vld_b && !seen) begin
        seen = 1'b1;
        total++;
        if (to_b !== 1'b0) begin bad++; $display("FAIL resume_clear got=%b want=0", to_b); end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL resume_valid got=none want=valid"); end
  endtask

  task automatic test_stuck_high();
    int nv_b = 0;
    int to_at = -1;
    do_reset(2, 1'b0);
    wq.delete();
    add_level(1'b0, 5);
    add_level(1'b1, 150);
    add_level(1'b0, 5);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      nv_b += int'(vld_b);
      if (to_b && to_at < 0) to_at = n_s;
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL stuck_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL stuck_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    total += 3;
    if (nv_b !== 0) begin bad++; $display("FAIL stuck_novalid got=%0d want=0", nv_b); end
    if (to_at !== 108) begin bad++; $display("FAIL stuck_when got=%0d want=108", to_at); end
    if (to_b !== 1'b1 || lk_b !== 1'b0) begin bad++; $display("FAIL stuck_flags got=to%b lk%b want=to1 lk0", to_b, lk_b); end
    wq.delete();
    add_pulses(30, 70, 3);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL unstuck_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL unstuck_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
  endtask

  task automatic test_boundary();
    int nv_b = 0;
    do_reset(2, 1'b0);
    wq.delete();
    add_level(1'b0, 5);
    add_pulses(30, 70, 3);
    add_pulses(30, 71, 1);
    add_pulses(30, 70, 1);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      nv_b += int'(vld_b);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL bound_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL bound_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    total += 3;
    if (nv_b !== 3) begin bad++; $display("FAIL bound_count got=%0d want=3", nv_b); end
    if (per_b !== 32'd100) begin bad++; $display("FAIL bound_exact got=%0d want=100", per_b); end
    if (to_b !== 1'b1) begin bad++; $display("FAIL bound_101 got=%b want=1", to_b); end
  endtask

  task automatic test_high_at_reset();
    int nv_a = 0;
    do_reset(3, 1'b1);
    total += 2;
    if (obs_a !== 67'd0) begin bad++; $display("FAIL hreset_a got=%h want=0", obs_a); end
    if (obs_b !== 67'd0) begin bad++; $display("FAIL hreset_b got=%h want=0", obs_b); end
    wq.delete();
    add_level(1'b1, 10);
    add_level(1'b0, 4);
    add_pulses(1, 4, 6);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL hrel_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL hrel_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
      if (vld_a) begin
        nv_a++;
        total++;
        if (per_a !== 32'd5 || hi_a !== 32'd1) begin bad++; $display("FAIL hrel_pair got=%0d/%0d want=5/1", per_a, hi_a); end
      end
    end
    total++;
    if (nv_a !== 5) begin bad++; $display("FAIL hrel_count got=%0d want=5", nv_a); end
  endtask

  task automatic test_reset_mid();
    int nv_a = 0;
    wq.delete();
    add_pulses(20, 80, 2);
    add_level(1'b1, 10);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL pre_mid_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL pre_mid_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    do_reset(1, 1'b1);
    total += 2;
    if (obs_a !== 67'd0) begin bad++; $display("FAIL mid_reset_a got=%h want=0", obs_a); end
    if (obs_b !== 67'd0) begin bad++; $display("FAIL mid_reset_b got=%h want=0", obs_b); end
    wq.delete();
    add_level(1'b1, 10);
    add_level(1'b0, 80);
    add_pulses(20, 80, 2);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      nv_a += int'(vld_a);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL post_mid_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL post_mid_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
    total += 2;
    if (nv_a !== 1) begin bad++; $display("FAIL post_mid_count got=%0d want=1", nv_a); end
    if (per_a !== 32'd100 || hi_a !== 32'd20) begin bad++; $display("FAIL post_mid_pair got=%0d/%0d want=100/20", per_a, hi_a); end
  endtask

  task automatic test_random();
    do_reset(2, 1'b0);
    wq.delete();
    add_level(1'b0, 3);
    repeat (40) add_pulses(int'($urandom_range(1, 40)), int'($urandom_range(1, 90)), 1);
    for (int i = 0; i < wq.size(); i++) begin
      tick(wq[i]);
      total += 2;
      if (obs_a !== exp_a) begin bad++; $display("FAIL rand_a cyc=%0d got=%h want=%h", n_s, obs_a, exp_a); end
      if (obs_b !== exp_b) begin bad++; $display("FAIL rand_b cyc=%0d got=%h want=%h", n_s, obs_b, exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_timeout_low();
    test_stuck_high();
    test_boundary();
    test_high_at_reset();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
